// File: rtl/decoder_pkg.sv
// Shared definitions for the 2-to-4 pulse decoder.
//   ONEHOT_W  : width of the one-hot output bus
//   state_t   : FSM state encoding (IDLE, HOLD)
//   cnt_width : hold-counter width, clog2 with a floor of one bit
package decoder_pkg;

  localparam int ONEHOT_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // A hold length of 1 still needs a one-bit counter so the register
  // never degenerates to zero width.
  function automatic int cnt_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/dec_2to4_comb.sv
// Purely combinational 2-bit index to 4-bit one-hot decoder.
// Ports:
//   idx    : encoded index (0..3)
//   onehot : 4'b0001 << idx
module dec_2to4_comb
  import decoder_pkg::*;
(
  input  logic [1:0]          idx,
  output logic [ONEHOT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    case (idx)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      default: onehot = 4'b1000;
    endcase
  end

endmodule

// File: rtl/decoder_2to4_pulse.sv
// Registered 2-to-4 one-hot decoder with a pulse-hold timer.
// Each accepted index drives one bit of y for HOLD_CYCLES cycles.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   d         : encoded index, sampled only on a transfer
//   d_valid   : source offers d this cycle
//   d_ready   : block can accept d this cycle
//   y         : registered one-hot output, zero when idle
//   y_valid   : y holds a decoded value
//   done      : high in the last hold cycle of each value
//   state_dbg : current FSM state (1 = HOLD), for observation only
//
// Handshake: a transfer happens on a rising edge where d_valid && d_ready.
// While d_valid is high and d_ready is low the request is simply not taken;
// the source keeps d and d_valid stable until it is. d_ready does not depend
// on d_valid.
module decoder_2to4_pulse
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          d,
  input  logic                d_valid,
  output logic                d_ready,
  output logic [ONEHOT_W-1:0] y,
  output logic                y_valid,
  output logic                done,
  output logic                state_dbg
);

  localparam int CW = cnt_width(HOLD_CYCLES);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [ONEHOT_W-1:0] dec_y;
  logic                last_cycle;
  logic                xfer;

  dec_2to4_comb u_dec (
    .idx    (d),
    .onehot (dec_y)
  );

  // The final hold cycle doubles as an acceptance slot so back-to-back
  // values follow each other without an idle gap.
  assign last_cycle = (state == HOLD) && (cnt == '0);
  assign d_ready    = !rst && ((state == IDLE) || (cnt == '0));
  assign xfer       = d_valid && d_ready;
  assign y_valid    = (state == HOLD);
  // Gated by rst so a reset landing on the last cycle suppresses the pulse.
  assign done       = !rst && last_cycle;
  assign state_dbg  = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      y     <= '0;
    end else if (xfer) begin
      state <= HOLD;
      cnt   <= CW'(HOLD_CYCLES - 1);
      y     <= dec_y;
    end else if (state == HOLD) begin
      if (cnt == '0) begin
        state <= IDLE;
        y     <= '0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_decoder_2to4_pulse.sv
// Bench for decoder_2to4_pulse: one instance with HOLD_CYCLES = 4 and one
// with HOLD_CYCLES = 1 share the same stimulus. A cycles-remaining model
// checks both every cycle; a vector table and hand sequences pin the
// documented scenarios with literal expectations.
module tb_decoder_2to4_pulse;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] d;
  logic       d_valid;

  logic       rdy4, yv4, done4, st4;
  logic [3:0] y4;
  logic       rdy1, yv1, done1, st1;
  logic [3:0] y1;

  int errors = 0;
  int checks = 0;
  bit model_en = 1'b0;

  decoder_2to4_pulse #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(rdy4),
    .y(y4), .y_valid(yv4), .done(done4), .state_dbg(st4)
  );

  decoder_2to4_pulse #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(rdy1),
    .y(y1), .y_valid(yv1), .done(done1), .state_dbg(st1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // left = number of cycles the current value is still to be shown.
  int         left4 = 0, left1 = 0;
  logic [3:0] val4 = '0, val1 = '0;

  task automatic model_step(input int h, inout int left, inout logic [3:0] val);
    if (rst) begin
      left = 0;
    end else if (d_valid && left <= 1) begin
      val  = 4'(1 << d);
      left = h;
    end else if (left > 0) begin
      left = left - 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(4, left4, val4);
    model_step(1, left1, val1);
  end

  always @(negedge clk) begin
    if (model_en) begin
      chk("m4_y",     y4,           (left4 > 0) ? val4 : 4'b0000);
      chk("m4_yv",    {3'b0, yv4},  {3'b0, left4 > 0});
      chk("m4_st",    {3'b0, st4},  {3'b0, left4 > 0});
      chk("m4_done",  {3'b0, done4},{3'b0, !rst && left4 == 1});
      chk("m4_ready", {3'b0, rdy4}, {3'b0, !rst && left4 <= 1});
      chk("m1_y",     y1,           (left1 > 0) ? val1 : 4'b0000);
      chk("m1_yv",    {3'b0, yv1},  {3'b0, left1 > 0});
      chk("m1_done",  {3'b0, done1},{3'b0, !rst && left1 == 1});
      chk("m1_ready", {3'b0, rdy1}, {3'b0, !rst && left1 <= 1});
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic dv, input logic [1:0] dd);
    @(posedge clk);
    #1;
    rst     = r;
    d_valid = dv;
    d       = dd;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       dv;
    logic [1:0] d;
    logic [3:0] y;
    logic       yv;
    logic       done;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic dv, input logic [1:0] dd,
                     input logic [3:0] ey, input logic eyv, input logic edn,
                     input logic erdy);
    vec_t v;
    v.rst = r; v.dv = dv; v.d = dd;
    v.y = ey; v.yv = eyv; v.done = edn; v.rdy = erdy;
    tbl.push_back(v);
  endtask

  task automatic expect4(input string name, input logic [3:0] ey, input logic eyv,
                         input logic edn, input logic erdy);
    chk({name, "_y"},     y4,           ey);
    chk({name, "_yv"},    {3'b0, yv4},  {3'b0, eyv});
    chk({name, "_done"},  {3'b0, done4},{3'b0, edn});
    chk({name, "_ready"}, {3'b0, rdy4}, {3'b0, erdy});
  endtask

  logic [3:0] exp_q[$];
  logic [3:0] onehot_tab [4];

  initial begin
    rst = 1'b1; d_valid = 1'b0; d = 2'd0;
    onehot_tab[0] = 4'b0001; onehot_tab[1] = 4'b0010;
    onehot_tab[2] = 4'b0100; onehot_tab[3] = 4'b1000;

    // reset held for three cycles
    for (int i = 0; i < 3; i++) add(1, 0, 0, 4'b0000, 0, 0, 0);
    // single decode of each index with an idle gap
    for (int k = 0; k < 4; k++) begin
      add(0, 1, 2'(k), 4'b0000, 0, 0, 1);
      for (int j = 0; j < 3; j++) add(0, 0, 0, onehot_tab[k], 1, 0, 0);
      add(0, 0, 0, onehot_tab[k], 1, 1, 1);
      add(0, 0, 0, 4'b0000, 0, 0, 1);
    end
    // back-to-back 2 then 3, d_valid held high
    add(0, 1, 2, 4'b0000, 0, 0, 1);
    for (int j = 0; j < 3; j++) add(0, 1, 3, 4'b0100, 1, 0, 0);
    add(0, 1, 3, 4'b0100, 1, 1, 1);
    for (int j = 0; j < 3; j++) add(0, 0, 0, 4'b1000, 1, 0, 0);
    add(0, 0, 0, 4'b1000, 1, 1, 1);
    add(0, 0, 0, 4'b0000, 0, 0, 1);
    // reset in the 2nd hold cycle of 1000 while a new value is offered
    add(0, 1, 3, 4'b0000, 0, 0, 1);
    add(0, 0, 0, 4'b1000, 1, 0, 0);
    add(1, 1, 2, 4'b1000, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 0, 1);
    add(0, 0, 0, 4'b0000, 0, 0, 1);
    // reset coinciding with an offered transfer from idle
    add(1, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 0, 1);

    @(posedge clk);
    #1;
    model_en = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].dv, tbl[i].d);
      @(negedge clk);
      expect4($sformatf("tbl%0d", i), tbl[i].y, tbl[i].yv, tbl[i].done, tbl[i].rdy);
    end

    // backpressure: d moves from 1 to 3 while 0010 is held
    drive(0, 1, 1); @(negedge clk); expect4("bp_idle", 4'b0000, 0, 0, 1);
    for (int j = 0; j < 3; j++) begin
      drive(0, 1, 3); @(negedge clk); expect4("bp_hold", 4'b0010, 1, 0, 0);
    end
    drive(0, 1, 3); @(negedge clk); expect4("bp_last", 4'b0010, 1, 1, 1);
    for (int j = 0; j < 3; j++) begin
      drive(0, 0, 0); @(negedge clk); expect4("bp_new", 4'b1000, 1, 0, 0);
    end
    drive(0, 0, 0); @(negedge clk); expect4("bp_newlast", 4'b1000, 1, 1, 1);
    drive(0, 0, 0); @(negedge clk); expect4("bp_end", 4'b0000, 0, 0, 1);

    // HOLD_CYCLES = 1 streaming: one value per cycle
    exp_q = {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    for (int j = 0; j < 6; j++) begin
      logic [3:0] e;
      drive(0, j < 4, 2'(j));
      @(negedge clk);
      e = exp_q.pop_front();
      chk("h1_y",     y1,            e);
      chk("h1_done",  {3'b0, done1}, {3'b0, e != 4'b0000});
      chk("h1_ready", {3'b0, rdy1},  4'b0001);
    end

    // randomized traffic, checked by the model on both instances
    for (int j = 0; j < 400; j++) begin
      drive(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)));
    end
    drive(0, 0, 0);
    repeat (6) drive(0, 0, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
